reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Purpose:
//   Generates NUM_OUT per-domain active-high resets that are asserted together
//   and released one at a time in ascending index order. A reset can be requested
//   in two ways: an asynchronous external request, which is synchronized and
//   debounced, or a single-cycle software request.
//
//   Sequence: HOLD (all outputs asserted for HOLD_CYCLES after the last request)
//             -> RELEASE (one output cleared every STEP_CYCLES)
//             -> RUN (all outputs cleared, rst_done high).
//   A request in any state returns the sequencer to HOLD.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset; overrides all requests
//   ext_rst_req  in   asynchronous external reset request, active-high
//   sw_rst_req   in   synchronous single-cycle software reset request
//   reset_out    out  [NUM_OUT] per-domain resets, registered
//   rst_done     out  high in RUN (every reset_out bit released), registered
//   state        out  [2] 00 HOLD, 01 RELEASE, 10 RUN
//   last_cause   out  [2] 00 rst, 01 ext_rst_req, 10 sw_rst_req
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int SYNC_STAGES     = 2,   // 2..4
  parameter int DEBOUNCE_CYCLES = 4,   // 1..255
  parameter int HOLD_CYCLES     = 16,  // 1..65535
  parameter int STEP_CYCLES     = 8,   // 1..65535
  parameter int NUM_OUT         = 4    // 1..16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ext_rst_req,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] reset_out,
  output logic               rst_done,
  output logic [1:0]         state,
  output logic [1:0]         last_cause
);

  localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [7:0]         DEB_MAX   = 8'(DEBOUNCE_CYCLES);
  localparam logic [15:0]        HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0]        STEP_LAST = 16'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0] LSB_ONE   = NUM_OUT'(1);

  localparam logic [1:0] CAUSE_RST = 2'b00;
  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'b00,
    ST_RELEASE = 2'b01,
    ST_RUN     = 2'b10
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronizer chain: the only logic that samples ext_rst_req directly.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (rst) sync_q[gi] <= 1'b0;
        else     sync_q[gi] <= ext_rst_req;
      end
    end else begin : g_rest
      always_ff @(posedge clk) begin
        if (rst) sync_q[gi] <= 1'b0;
        else     sync_q[gi] <= sync_q[gi-1];
      end
    end
  end

  logic sync_lvl;
  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce: saturating run-length counter of the synchronized level.
  // ext_deb is registered from the next-state count, so ext_deb_q is high in
  // exactly the cycles where deb_cnt_q equals DEBOUNCE_CYCLES.
  // ---------------------------------------------------------------------------
  logic [7:0] deb_cnt_q, deb_cnt_d;
  logic       ext_deb_q;

  always_comb begin
    deb_cnt_d = deb_cnt_q;
    if (!sync_lvl) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q != DEB_MAX) begin
      deb_cnt_d = deb_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_q <= '0;
      ext_deb_q <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      ext_deb_q <= (deb_cnt_d == DEB_MAX);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;        // next output to release
  logic [NUM_OUT-1:0] reset_out_q, reset_out_d;
  logic               rst_done_q, rst_done_d;
  logic [1:0]         last_cause_q, last_cause_d;

  logic               req_active;
  logic [NUM_OUT-1:0] clr_mask;

  assign req_active = ext_deb_q | sw_rst_req;

  // One-hot select of the output addressed by idx_q.
  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_mask
    assign clr_mask[gi] = (idx_q == IDX_W'(gi));
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    reset_out_d  = reset_out_q;
    rst_done_d   = rst_done_q;
    last_cause_d = last_cause_q;

    if (req_active) begin
      // Requests keep the hold counter at zero, so the hold time starts
      // when the request goes away.
      state_d      = ST_HOLD;
      cnt_d        = '0;
      idx_d        = '0;
      reset_out_d  = '1;
      rst_done_d   = 1'b0;
      last_cause_d = ext_deb_q ? CAUSE_EXT : CAUSE_SW;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d       = '0;
            reset_out_d = reset_out_q & ~LSB_ONE;
            if (NUM_OUT == 1) begin
              // The only output is released here, so skip RELEASE.
              state_d    = ST_RUN;
              rst_done_d = 1'b1;
            end else begin
              state_d = ST_RELEASE;
              idx_d   = IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end

        ST_RELEASE: begin
          if (cnt_q == STEP_LAST) begin
            cnt_d       = '0;
            reset_out_d = reset_out_q & ~clr_mask;
            idx_d       = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
              state_d    = ST_RUN;
              rst_done_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end

        ST_RUN: begin
          // Stay released until a request or rst arrives.
        end

        default: begin
          // An unreachable encoding resets the sequence.
          state_d     = ST_HOLD;
          cnt_d       = '0;
          idx_d       = '0;
          reset_out_d = '1;
          rst_done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_HOLD;
      cnt_q        <= '0;
      idx_q        <= '0;
      reset_out_q  <= '1;
      rst_done_q   <= 1'b0;
      last_cause_q <= CAUSE_RST;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      reset_out_q  <= reset_out_d;
      rst_done_q   <= rst_done_d;
      last_cause_q <= last_cause_d;
    end
  end

  assign reset_out  = reset_out_q;
  assign rst_done   = rst_done_q;
  assign state      = state_q;
  assign last_cause = last_cause_q;

endmodule
